bcd_encoder: RTL and testbench
==============================

Name: bcd_encoder

Overview:
- Registered decimal-to-BCD encoder: converts a 10-line one-hot decimal input (lines 0..9) to a 4-bit BCD code.
- Sits between decimal keypad/selector logic and downstream BCD consumers (7-segment decoders, BCD arithmetic).
- Multi-hot input is resolved by priority. Status flags report valid and malformed input.

Parameters:
- HIGH_PRIORITY, default 1. 1 = highest-index asserted line wins; 0 = lowest-index asserted line wins.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  encode enable.
- cin  input  10  decimal input lines; bit k represents digit k.
- cout  output  4  registered BCD code, 0..9.
- valid  output  1  registered; cout holds a code encoded from a non-zero cin while en=1.
- err  output  1  registered; the last sampled cin was not exactly one-hot while en=1.

Behaviour:
- Interface: one clock; reset is synchronous and active-high, named clk and rst.
- Reset: on a rising clk edge with rst=1, cout=4'd0, valid=0, err=0. Reset overrides en.
- Latency: outputs reflect the inputs sampled at the previous rising edge (1 cycle). No combinational path from inputs to outputs.
- en=1, cin exactly one-hot with bit k set: next cycle cout=k, valid=1, err=0.
  - Example: cin=10'b0000000001 -> cout=0; cin=10'b1000000000 -> cout=9.
- en=1, cin multi-hot: cout = index chosen by HIGH_PRIORITY (highest or lowest set bit); valid=1, err=1.
- en=1, cin=0: cout=0, valid=0, err=1.
- en=0: cout=0, valid=0, err=0 next cycle, regardless of cin.
- cout is never greater than 9; codes 10..15 are never produced.
- Back-to-back changes: a new cin every cycle gives a new cout every cycle. No hold-off, no handshake.
- Reset asserted mid-stream: outputs clear on that edge. The first post-reset encode appears one cycle after rst deasserts with en=1.
- Outputs are constant between edges; input changes between edges have no effect.

Decomposition:
- Shared package bcd_pkg:
  - constants DEC_LINES=10 and BCD_W=4;
  - BCD digit typedef (logic [3:0]);
  - constant BCD_ZERO.
- One sub-module, onehot_check: combinational, 10-bit input.
  - Outputs is_zero and is_multi (popcount > 1).
  - Used to build err.
- Priority encode and the output registers live in the top level.

Test Plan:
- Reset: rst=1 for 2 cycles with en=1, cin=10'b0000100000 -> cout=0, valid=0, err=0 during reset; cout=5, valid=1 one cycle after rst drops.
- Walking one-hot: en=1, cin=1<<k for k=0..9, one per cycle -> cout=k with valid=1, err=0, each one cycle later.
- Multi-hot: cin=10'b1000000101, HIGH_PRIORITY=1 -> cout=9, valid=1, err=1. Same input with HIGH_PRIORITY=0 -> cout=0, valid=1, err=1.
- Zero input: en=1, cin=0 -> cout=0, valid=0, err=1.
- Disable: en=0, cin=10'b0010000000 -> cout=0, valid=0, err=0. Raise en -> cout=7 next cycle.
- Mid-stream reset: en=1, cin=10'b0100000000 giving cout=8; pulse rst for one cycle -> cout=0, valid=0 on that edge; cout=8 resumes one cycle after rst drops.

Source files
------------

// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared constants and types for the decimal-to-BCD encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    localparam int DEC_LINES = 10;
    localparam int BCD_W     = 4;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    localparam bcd_digit_t BCD_ZERO = '0;

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_encoder_onehot_check.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_check
//  Description : Flags an all-zero or multi-hot decimal input vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module onehot_check
    import bcd_pkg::*;
(
    input  logic [DEC_LINES-1:0] i_lines,
    output logic                 is_zero,
    output logic                 is_multi
);

    logic [DEC_LINES-1:0] w_low_cleared;

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign w_low_cleared = i_lines & (i_lines - DEC_LINES'(1));
    assign is_zero       = ~|i_lines;
    assign is_multi      = |w_low_cleared;

endmodule : onehot_check
`default_nettype wire

// File: rtl/bcd_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_encoder
//  Description : Registered 10-line decimal to BCD priority encoder with
//                valid / malformed-input status flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_encoder
    import bcd_pkg::*;
#(
    parameter int HIGH_PRIORITY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DEC_LINES-1:0] cin,
    output bcd_digit_t           cout,
    output logic                 valid,
    output logic                 err
);

    bcd_digit_t w_code;
    logic       w_is_zero;
    logic       w_is_multi;

    bcd_digit_t r_cout;
    logic       r_valid;
    logic       r_err;

    onehot_check u_onehot_check (
        .i_lines  (cin),
        .is_zero  (w_is_zero),
        .is_multi (w_is_multi)
    );

    // Later loop iterations overwrite earlier ones, so scan order sets the winner.
    generate
        if (HIGH_PRIORITY != 0) begin : g_high_priority
            always_comb begin
                w_code = BCD_ZERO;
                for (int i = 0; i < DEC_LINES; i++) begin
                    if (cin[i]) w_code = BCD_W'(i);
                end
            end
        end else begin : g_low_priority
            always_comb begin
                w_code = BCD_ZERO;
                for (int i = DEC_LINES - 1; i >= 0; i--) begin
                    if (cin[i]) w_code = BCD_W'(i);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cout  <= BCD_ZERO;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else if (en) begin
            r_cout  <= w_code;
            r_valid <= ~w_is_zero;
            r_err   <= w_is_zero | w_is_multi;
        end else begin
            r_cout  <= BCD_ZERO;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end
    end

    assign cout  = r_cout;
    assign valid = r_valid;
    assign err   = r_err;

endmodule : bcd_encoder
`default_nettype wire

// File: tb/tb_bcd_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_encoder
//  Description : Self-checking bench for bcd_encoder, both priority modes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_encoder;

    typedef struct {
        logic       rst;
        logic       en;
        logic [9:0] cin;
        logic [3:0] hi;
        logic [3:0] lo;
        logic       v;
        logic       e;
    } vec_t;

    typedef struct {
        logic [3:0] hi;
        logic [3:0] lo;
        logic       v;
        logic       e;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [9:0] cin = '0;
    logic [3:0] cout_hi, cout_lo;
    logic       valid_hi, valid_lo, err_hi, err_lo;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    bcd_encoder #(.HIGH_PRIORITY(1)) dut_hi (
        .clk(clk), .rst(rst), .en(en), .cin(cin),
        .cout(cout_hi), .valid(valid_hi), .err(err_hi)
    );

    bcd_encoder #(.HIGH_PRIORITY(0)) dut_lo (
        .clk(clk), .rst(rst), .en(en), .cin(cin),
        .cout(cout_lo), .valid(valid_lo), .err(err_lo)
    );

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Independent reference: scan bits, count ones.
    function automatic exp_t model(input logic r, input logic e_n, input logic [9:0] c);
        exp_t x;
        x = '{4'd0, 4'd0, 1'b0, 1'b0};
        if (!r && e_n) begin
            for (int i = 0; i < 10; i++) if (c[i]) x.hi = 4'(i);
            for (int i = 9; i >= 0; i--) if (c[i]) x.lo = 4'(i);
            x.v = (c != 10'd0);
            x.e = ($countones(c) != 1);
        end
        return x;
    endfunction

    task automatic drive(input logic r, input logic e_n, input logic [9:0] c, input exp_t x);
        @(negedge clk);
        rst = r;
        en  = e_n;
        cin = c;
        sb.push_back(x);
    endtask

    // Monitor: one expected record retires per rising edge.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            chk("cout_hi",  cout_hi,        x.hi);
            chk("cout_lo",  cout_lo,        x.lo);
            chk("valid_hi", {3'b0, valid_hi}, {3'b0, x.v});
            chk("valid_lo", {3'b0, valid_lo}, {3'b0, x.v});
            chk("err_hi",   {3'b0, err_hi},   {3'b0, x.e});
            chk("err_lo",   {3'b0, err_lo},   {3'b0, x.e});
            chk("cout_range", {3'b0, (cout_hi > 4'd9) | (cout_lo > 4'd9)}, 4'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tbl [16];

    initial begin
        exp_t x;
        //            rst   en    cin            hi    lo    v     e
        tbl[0]  = '{1'b1, 1'b1, 10'b0000100000, 4'd0, 4'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 10'b0000100000, 4'd0, 4'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 10'b0000100000, 4'd5, 4'd5, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 10'b1000000101, 4'd9, 4'd0, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 10'b0000000000, 4'd0, 4'd0, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 10'b0010000000, 4'd0, 4'd0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 10'b0010000000, 4'd7, 4'd7, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 10'b0100000000, 4'd8, 4'd8, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 10'b0100000000, 4'd0, 4'd0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 10'b0100000000, 4'd8, 4'd8, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 10'b0000011000, 4'd4, 4'd3, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 10'b1111111111, 4'd9, 4'd0, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 10'b0110000000, 4'd8, 4'd7, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 10'b1111111111, 4'd0, 4'd0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 10'b1000000000, 4'd9, 4'd9, 1'b1, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 10'b1000000000, 4'd0, 4'd0, 1'b0, 1'b0};

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].cin,
                  '{tbl[i].hi, tbl[i].lo, tbl[i].v, tbl[i].e});
        end

        // Walking one-hot, back to back.
        for (int k = 0; k < 10; k++) begin
            logic [9:0] c;
            c = 10'd1 << k;
            drive(1'b0, 1'b1, c, '{4'(k), 4'(k), 1'b1, 1'b0});
        end

        // Mid-cycle input wiggle must not leak to the outputs before the edge.
        drive(1'b0, 1'b1, 10'b0000001000, '{4'd3, 4'd3, 1'b1, 1'b0});
        @(posedge clk);
        #2;
        cin = 10'b1000000001;
        #1;
        chk("hold_cout_hi", cout_hi, 4'd3);
        chk("hold_cout_lo", cout_lo, 4'd3);
        cin = 10'b0000001000;

        // Random traffic against the reference model.
        for (int n = 0; n < 60; n++) begin
            logic       r, e_n;
            logic [9:0] c;
            r   = ($urandom_range(0, 15) == 0);
            e_n = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 2))
                0: c = 10'd1 << $urandom_range(0, 9);
                1: c = 10'($urandom_range(0, 1023));
                default: c = '0;
            endcase
            x = model(r, e_n, c);
            drive(r, e_n, c, x);
        end

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_bcd_encoder
`default_nettype wire
